// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the mini computer control path: opcodes, ALU ops,
// stepper one-hot codes, flag bit positions and the control word layout.
package instr_sequencer_pkg;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  localparam logic [3:0] OPC_LD    = 4'b0000;
  localparam logic [3:0] OPC_ST    = 4'b0001;
  localparam logic [3:0] OPC_DATA  = 4'b0010;
  localparam logic [3:0] OPC_JMPR  = 4'b0011;
  localparam logic [3:0] OPC_JMP   = 4'b0100;
  localparam logic [3:0] OPC_JCAEZ = 4'b0101;
  localparam logic [3:0] OPC_CLF   = 4'b0110;
  localparam logic [3:0] OPC_HALT  = 4'b0111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic       ram_en;
    logic       acc_en;
    logic       iar_en;
    logic [3:0] r_en;
    logic       mar_set;
    logic       acc_set;
    logic       ram_set;
    logic       tmp_set;
    logic       iar_set;
    logic       ir_set;
    logic [3:0] r_set;
    logic       b1;
    logic [2:0] op;
    logic       flags_set;
    logic       flags_clr;
    logic       halt_req;
  } ctrl_t;

  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/instr_sequencer_step_counter.sv
// Six-step one-hot ring counter with a hold input; also intended to back a
// future single-step debug mode.
module instr_sequencer_step_counter
  import instr_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic [5:0] step
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= S1;
    end else if (!hold) begin
      step <= {step[4:0], step[5]};
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Control sequencer: stepper, instruction decoder and CPU flags register
// driving every bus enable, load strobe and ALU op of the datapath.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic [3:0] flags_in,
  output logic       ram_en,
  output logic       acc_en,
  output logic       iar_en,
  output logic [3:0] r_en,
  output logic       mar_set,
  output logic       acc_set,
  output logic       ram_set,
  output logic       tmp_set,
  output logic       iar_set,
  output logic       ir_set,
  output logic [3:0] r_set,
  output logic       b1,
  output logic [2:0] op,
  output logic [3:0] flags_q,
  output logic [5:0] step
);

  ctrl_t      c;
  logic       halt_q;
  logic       hold;
  logic       active;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       is_cmp;

  assign ra     = ir[3:2];
  assign rb     = ir[1:0];
  assign is_cmp = (ir[6:4] == ALU_CMP);
  assign hold   = halt_q | c.halt_req;

  instr_sequencer_step_counter u_step (
    .clk   (clk),
    .rst_n (rst),
    .hold  (hold),
    .step  (step)
  );

  always_comb begin
    c = '0;
    case (step)
      S1: begin
        c.iar_en = 1'b1; c.b1 = 1'b1; c.mar_set = 1'b1; c.acc_set = 1'b1;
      end
      S2: begin
        c.ram_en = 1'b1; c.ir_set = 1'b1;
      end
      S3: begin
        c.acc_en = 1'b1; c.iar_set = 1'b1;
      end
      S4: begin
        if (ir[7]) begin
          c.r_en = reg_sel(rb); c.tmp_set = 1'b1;
        end else begin
          case (ir[7:4])
            OPC_LD, OPC_ST: begin
              c.r_en = reg_sel(ra); c.mar_set = 1'b1;
            end
            OPC_DATA, OPC_JCAEZ: begin
              c.iar_en = 1'b1; c.b1 = 1'b1; c.mar_set = 1'b1; c.acc_set = 1'b1;
            end
            OPC_JMPR: begin
              c.r_en = reg_sel(rb); c.iar_set = 1'b1;
            end
            OPC_JMP: begin
              c.iar_en = 1'b1; c.mar_set = 1'b1;
            end
            OPC_CLF:  c.flags_clr = 1'b1;
            OPC_HALT: c.halt_req  = HALT_EN;
            default: ;
          endcase
        end
      end
      S5: begin
        if (ir[7]) begin
          c.r_en      = reg_sel(ra);
          c.op        = ir[6:4];
          c.flags_set = 1'b1;
          c.acc_set   = ~is_cmp;
        end else begin
          case (ir[7:4])
            OPC_LD, OPC_DATA: begin
              c.ram_en = 1'b1; c.r_set = reg_sel(rb);
            end
            OPC_ST: begin
              c.r_en = reg_sel(rb); c.ram_set = 1'b1;
            end
            OPC_JMP: begin
              c.ram_en = 1'b1; c.iar_set = 1'b1;
            end
            OPC_JCAEZ: begin
              c.acc_en = 1'b1; c.iar_set = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S6: begin
        if (ir[7]) begin
          if (!is_cmp) begin
            c.acc_en = 1'b1; c.r_set = reg_sel(rb);
          end
        end else begin
          case (ir[7:4])
            OPC_DATA: begin
              c.acc_en = 1'b1; c.iar_set = 1'b1;
            end
            OPC_JCAEZ: begin
              if ((ir[3:0] & flags_q) != 4'b0000) begin
                c.ram_en = 1'b1; c.iar_set = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Reset and halt both silence the datapath regardless of the decoded step.
  assign active  = rst & ~halt_q;
  assign ram_en  = active & c.ram_en;
  assign acc_en  = active & c.acc_en;
  assign iar_en  = active & c.iar_en;
  assign r_en    = active ? c.r_en : 4'b0000;
  assign mar_set = active & c.mar_set;
  assign acc_set = active & c.acc_set;
  assign ram_set = active & c.ram_set;
  assign tmp_set = active & c.tmp_set;
  assign iar_set = active & c.iar_set;
  assign ir_set  = active & c.ir_set;
  assign r_set   = active ? c.r_set : 4'b0000;
  assign b1      = active & c.b1;
  assign op      = active ? c.op : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 4'b0000;
      halt_q  <= 1'b0;
    end else if (!halt_q) begin
      if (c.halt_req) begin
        halt_q <= 1'b1;
      end
      if (c.flags_clr) begin
        flags_q <= 4'b0000;
      end else if (c.flags_set) begin
        flags_q <= flags_in;
      end
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Control sequencer for the 8-bit mini computer. Contains the 6-step stepper, the instruction decoder and the CPU flags register. It drives every enable and set strobe, the bus1 force, and the ALU op for the datapath in cpu_top. Each instruction takes a fixed six clk cycles: three fetch steps, then up to three execute steps.

Parameters:
HALT_EN, 1, 1 = opcode 0111 halts the stepper; 0 = opcode 0111 is a NOP.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ir  in  8  instruction register contents; sampled in steps 4-6 only
flags_in  in  4  ALU flags {C,A,E,Z}
ram_en, acc_en, iar_en  out  1 each  bus drive enables
r_en  out  4  R3..R0 bus drive enables
mar_set, acc_set, ram_set, tmp_set, iar_set, ir_set  out  1 each  register load strobes
r_set  out  4  R3..R0 load strobes
b1  out  1  force bus1 = 8'h01
op  out  3  ALU op
flags_q  out  4  latched flags {C,A,E,Z}
step  out  6  one-hot current step (debug)

Behaviour:
- Reset (rst low): step=6'b000001, flags_q=0, halt cleared, all strobe/enable outputs forced 0, op=000. Takes effect asynchronously and aborts any instruction mid-flight.
- Stepper: one-hot ring 1->2->...->6->1, advancing once per clk. When halted it holds at step 4.
- Outputs are combinational from step, ir and flags_q. The datapath samples set strobes on the next rising clk. At most one *_en/r_en bit is high in any cycle.
- op defaults to 000 (ADD) when not otherwise stated.
- Fetch:
  - s1: iar_en, b1, mar_set, acc_set.
  - s2: ram_en, ir_set.
  - s3: acc_en, iar_set.
- Fields: RA=ir[3:2], RB=ir[1:0]. ALU ops: ADD 000, SHR 001, SHL 010, NOT 011, AND 100, OR 101, XOR 110, CMP 111.
- ALU (ir[7]=1):
  - s4: r_en[RB], tmp_set.
  - s5: r_en[RA], op=ir[6:4], flags_set; acc_set unless CMP.
  - s6: acc_en, r_set[RB] unless CMP.
- LD 0000: s4 r_en[RA], mar_set. s5 ram_en, r_set[RB].
- ST 0001: s4 r_en[RA], mar_set. s5 r_en[RB], ram_set.
- DATA 0010: s4 iar_en, b1, mar_set, acc_set. s5 ram_en, r_set[RB]. s6 acc_en, iar_set.
- JMPR 0011: s4 r_en[RB], iar_set.
- JMP 0100: s4 iar_en, mar_set. s5 ram_en, iar_set.
- JCAEZ 0101:
  - s4 iar_en, b1, mar_set, acc_set.
  - s5 acc_en, iar_set.
  - s6 ram_en, iar_set only if (ir[3:0] & flags_q) != 0.
  - Mask ir[3:0] bit order is {C,A,E,Z}.
- CLF 0110: s4 clears flags_q to 0 at the clock edge; no bus activity.
- 0111:
  - HALT_EN=1: at s4, latch halt. step stays s4 with all outputs 0 until reset.
  - HALT_EN=0: NOP.
- Unused execute steps drive all outputs 0 but still consume their cycle.
- flags_q loads flags_in at the rising edge ending an ALU s5 (including CMP). It is otherwise held.
- RA==RB is legal; the same register index is used in both steps.

Decomposition:
- cpu_pkg: opcode constants, ALU op encodings, step one-hot constants, flag bit indices (C=3, A=2, E=1, Z=0).
- Sub-module step_counter: one-hot ring with async active-low reset and hold input. Shared with a future single-step debug mode.

Test Plan:
- Release reset, ir=8'h00: step cycles 000001->...->100000->000001. s1 asserts iar_en, b1, mar_set, acc_set, op=000. s2 ram_en, ir_set. s3 acc_en, iar_set.
- ir=8'h86 (ADD, RA=1, RB=2): s4 r_en=0100, tmp_set. s5 r_en=0010, acc_set, op=000. s6 acc_en, r_set=0100.
- ir=8'hF1, flags_in=4'b0010 (CMP): s5 op=111, acc_set=0. s6 all 0. flags_q=0010 after s5.
- flags_q Z=1, ir=8'h51: s6 ram_en, iar_set. Repeat with flags_q=0: s6 all 0.
- Start with flags_q=1111, ir=8'h60: flags_q=0000 after s4. Then ir=8'h70: step frozen at 001000 and outputs 0 for 20 cycles.
- Pull rst low mid-s5 of a LD: immediately step=000001, outputs 0, flags_q=0. On release, s1 fetch strobes resume.
